pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Parametrised supervisor for NUM_CH PLL instances driven from the board crystal.
- Per channel, it does four things:
  - synchronises the raw lock signal;
  - sequences the PLL reset;
  - qualifies lock over a settle window;
  - detects lock loss and retries up to a limit.
- Produces per-channel ready flags and an aggregate all_ready that downstream clock-domain reset logic consumes.

Parameters:
- NUM_CH, 2, number of supervised PLL channels (1..8).
- SYNC_STAGES, 2, synchroniser depth on pll_locked_raw (>=2).
- PLL_RST_CYCLES, 16, cycles pll_reset_req is held high per reset attempt (>=1).
- SETTLE_CYCLES, 1024, consecutive synchronised-lock cycles required before ready (>=1).
- TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before a retry (>SETTLE_CYCLES).
- MAX_RETRIES, 3, timeouts tolerated before the channel is declared failed (>=0).

Ports:
- clk_in, input, 1, supervisor clock (free-running crystal clock).
- reset, input, 1, synchronous active-high reset.
- pll_locked_raw, input, NUM_CH, asynchronous lock outputs from the PLLs.
- pll_reset_req, output, NUM_CH, active-high reset to each PLL.
- ch_ready, output, NUM_CH, channel locked and qualified.
- ch_fail, output, NUM_CH, sticky: retries exhausted.
- all_ready, output, 1, AND of ch_ready.
- lock_lost, output, NUM_CH, one-cycle pulse on loss of qualified lock.

Behaviour:
- Reset:
  - Every channel enters RESET_PLL with all counters cleared.
  - Outputs during reset: pll_reset_req = all ones, ch_ready = 0, ch_fail = 0, all_ready = 0, lock_lost = 0.
- Synchronisation: each pll_locked_raw bit passes through SYNC_STAGES flops, giving lk. All decisions use lk only, so latency from raw to lk is SYNC_STAGES cycles.
- All outputs are registered.
- Per-channel FSM (independent per channel; one shared cycle counter of width clog2(max(TIMEOUT_CYCLES, SETTLE_CYCLES, PLL_RST_CYCLES)+1)):
  - RESET_PLL:
    - pll_reset_req = 1.
    - After exactly PLL_RST_CYCLES cycles in the state, go to WAIT_LOCK and clear the counter.
  - WAIT_LOCK:
    - pll_reset_req = 0.
    - lk = 1 → SETTLE, counter cleared.
    - Counter reaches TIMEOUT_CYCLES-1 with lk = 0:
      - retries < MAX_RETRIES → retries+1, go to RESET_PLL;
      - otherwise → FAIL.
  - SETTLE:
    - lk = 0 → WAIT_LOCK. The timeout counter restarts from 0; the retry count is unchanged.
    - SETTLE_CYCLES consecutive lk = 1 cycles → LOCKED, retries cleared.
  - LOCKED:
    - ch_ready = 1.
    - lk = 0 → lock_lost pulses high for one cycle, ch_ready drops on the same edge, go to RESET_PLL. Retries restart at 0.
  - FAIL:
    - ch_fail = 1, pll_reset_req = 1 (PLL held in reset), ch_ready = 0.
    - Terminal until reset.
- all_ready:
  - Registered AND of the next-state ch_ready bits, so it is cycle-aligned with ch_ready.
  - Any single channel dropping forces all_ready = 0 on the same edge.
- Boundary cases:
  - Lock-loss glitch: a one-cycle lk drop in LOCKED counts as loss; there is no filtering after qualification.
  - Lock edge at timeout: lk rising on the same cycle the timeout expires → SETTLE wins; no retry is charged.
  - MAX_RETRIES = 0: the first timeout goes straight to FAIL.
  - Reset mid-operation: returns every channel to RESET_PLL on the next edge regardless of state; sticky ch_fail clears.
- Total time to ready with an immediately-locking PLL: PLL_RST_CYCLES + SYNC_STAGES + SETTLE_CYCLES + 1 cycles after reset deasserts.

Optional Feature:
- PLL_LOCK_LOSS_COUNT_EN defined:
  - Adds output loss_count, NUM_CH*8 bits.
  - One saturating 8-bit counter per channel, incremented on each lock_lost pulse.
  - Holds at 255; cleared only by reset.
- Not defined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared defines/package `pll_supervisor_pkg`:
  - state encoding: RESET_PLL = 0, WAIT_LOCK = 1, SETTLE = 2, LOCKED = 3, FAIL = 4 (3-bit);
  - counter-width and retry-width clog2 helpers;
  - default cycle constants alongside the existing PLL_*MHZ defines.
- Sub-module `pll_lock_fsm`: one channel's synchroniser, FSM, counters and optional loss counter.
- Top level: generate loop over NUM_CH plus the all_ready reduction.

Test Plan:
(All scenarios use NUM_CH=2, SYNC=2, PLL_RST=8, SETTLE=16, TIMEOUT=64, MAX_RETRIES=2.)
1. Nominal lock: raw = 2'b11 from the first cycle after reset → pll_reset_req high for 8 cycles; ch_ready = 2'b11 and all_ready = 1 at cycle 8+2+16+1 = 27.
2. Settle interruption: ch0 raw drops for 1 cycle at SETTLE count 10 → ch0 returns to WAIT_LOCK; ready is delayed by a full 16-cycle settle; retries stay 0.
3. Retry then fail: ch1 raw held 0 → three 64-cycle WAIT_LOCK windows, each preceded by an 8-cycle reset; ch_fail[1] = 1 and pll_reset_req[1] = 1 permanently; ch0 unaffected; all_ready = 0.
4. Lock loss: both channels ready, ch0 raw low for 1 cycle → lock_lost[0] is a single pulse; ch_ready[0] and all_ready fall on the same edge; pll_reset_req[0] high for 8 cycles; ready returns after the full sequence.
5. Mid-operation reset: assert reset for 1 cycle while ch1 is in FAIL and ch0 is LOCKED → all outputs return to reset values on the next edge; nominal sequence repeats.
6. PLL_LOCK_LOSS_COUNT_EN: 300 lock-loss events on ch0 → loss_count[7:0] = 255 (saturated); loss_count[15:8] = 0.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// rtl/pll_supervisor_pkg.sv - shared state encoding, width helpers and default timing for the PLL lock supervisor
package pll_supervisor_pkg;

  // Board clocking: crystal reference and the synthesised PLL outputs
  localparam int PLL_XTAL_MHZ = 25;
  localparam int PLL_CORE_MHZ = 200;
  localparam int PLL_IO_MHZ   = 100;

  // Default supervisor timing, in crystal cycles
  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_SETTLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_RETRIES    = 3;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // One counter serves all timed states, so it must hold the largest terminal count
  function automatic int cnt_width(input int timeout, input int settle, input int rst);
    int m;
    m = timeout;
    if (settle > m) m = settle;
    if (rst > m) m = rst;
    return $clog2(m + 1);
  endfunction

  // Retry counter is at least one bit even when no retries are allowed
  function automatic int retry_width(input int max_retries);
    return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
  endfunction

endpackage

// File: rtl/pll_lock_fsm.sv
// rtl/pll_lock_fsm.sv - one channel: lock synchroniser, reset/qualify/retry FSM, optional loss counter (PLL_LOCK_LOSS_COUNT_EN)
module pll_lock_fsm
  import pll_supervisor_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       locked_raw,
  output logic       reset_req,
  output logic       ready,
  output logic       ready_next,
  output logic       fail,
  output logic       lost
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  output logic [7:0] loss_count
`endif
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES, SETTLE_CYCLES, PLL_RST_CYCLES);
  localparam int RW = retry_width(MAX_RETRIES);
  localparam logic [CW-1:0] RST_LAST     = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   lk;
  pll_state_e             state, state_next;
  logic [CW-1:0]          cnt, cnt_next;
  logic [RW-1:0]          retries, retries_next;
  logic                   reset_req_next, fail_next, lost_next;

  assign lk = sync[SYNC_STAGES-1];

  // Lock synchroniser; flushed while the PLL is held in reset so a stale lock is never qualified
  always_ff @(posedge clk_in) begin
    if (reset || reset_req) sync <= '0;
    else                    sync <= {sync[SYNC_STAGES-2:0], locked_raw};
  end

  // Next-state, counter and registered-output decode
  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 1'b1;
    retries_next = retries;
    lost_next    = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      WAIT_LOCK: begin
        // A lock edge coinciding with the timeout wins and costs no retry
        if (lk) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_next = '0;
          if (retries < RETRY_MAX) begin
            retries_next = retries + 1'b1;
            state_next   = RESET_PLL;
          end else begin
            state_next = FAIL;
          end
        end
      end
      SETTLE: begin
        if (!lk) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_next   = LOCKED;
          cnt_next     = '0;
          retries_next = '0;
        end
      end
      LOCKED: begin
        cnt_next = '0;
        if (!lk) begin
          state_next   = RESET_PLL;
          retries_next = '0;
          lost_next    = 1'b1;
        end
      end
      FAIL: begin
        cnt_next = '0;
      end
      default: begin
        state_next = RESET_PLL;
        cnt_next   = '0;
      end
    endcase
    reset_req_next = (state_next == RESET_PLL) || (state_next == FAIL);
    ready_next     = (state_next == LOCKED);
    fail_next      = (state_next == FAIL);
  end

  // State, counters and outputs registered together
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retries   <= '0;
      reset_req <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
      lost      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      retries   <= retries_next;
      reset_req <= reset_req_next;
      ready     <= ready_next;
      fail      <= fail_next;
      lost      <= lost_next;
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  // Saturating count of qualified-lock losses
  always_ff @(posedge clk_in) begin
    if (reset)                                 loss_count <= '0;
    else if (lost_next && loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
  end
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - NUM_CH PLL lock supervisor with aggregate ready (optional PLL_LOCK_LOSS_COUNT_EN loss counters)
module pll_lock_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   pll_locked_raw,
  output logic [NUM_CH-1:0]   pll_reset_req,
  output logic [NUM_CH-1:0]   ch_ready,
  output logic [NUM_CH-1:0]   ch_fail,
  output logic                all_ready,
  output logic [NUM_CH-1:0]   lock_lost
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  output logic [NUM_CH*8-1:0] loss_count
`endif
);

  logic [NUM_CH-1:0] ready_next;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pll_lock_fsm #(
      .SYNC_STAGES    (SYNC_STAGES),
      .PLL_RST_CYCLES (PLL_RST_CYCLES),
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .MAX_RETRIES    (MAX_RETRIES)
    ) u_fsm (
      .clk_in     (clk_in),
      .reset      (reset),
      .locked_raw (pll_locked_raw[i]),
      .reset_req  (pll_reset_req[i]),
      .ready      (ch_ready[i]),
      .ready_next (ready_next[i]),
      .fail       (ch_fail[i]),
      .lost       (lock_lost[i])
`ifdef PLL_LOCK_LOSS_COUNT_EN
      ,
      .loss_count (loss_count[i*8 +: 8])
`endif
    );
  end

  // Built from next-state ready bits so it lands on the same edge as ch_ready
  always_ff @(posedge clk_in) begin
    if (reset) all_ready <= 1'b0;
    else       all_ready <= &ready_next;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [1:0]  raw;
  logic [1:0]  pll_reset_req, ch_ready, ch_fail, lock_lost;
  logic        all_ready;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [15:0] loss_count;
`endif

  int vec_count   = 0;
  int miscompares = 0;
  int n           = 0;

  always #5 clk_in = ~clk_in;

  pll_lock_supervisor #(
    .NUM_CH         (2),
    .SYNC_STAGES    (2),
    .PLL_RST_CYCLES (8),
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (64),
    .MAX_RETRIES    (2)
  ) dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .pll_locked_raw (raw),
    .pll_reset_req  (pll_reset_req),
    .ch_ready       (ch_ready),
    .ch_fail        (ch_fail),
    .all_ready      (all_ready),
    .lock_lost      (lock_lost)
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    .loss_count     (loss_count)
`endif
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // n counts rising edges since the last reset edge; checks happen on the falling edge
  task automatic advance_to(input int target);
    while (n < target) begin
      @(negedge clk_in);
      n++;
    end
  endtask

  task automatic apply_reset(input logic [1:0] raw_after);
    @(negedge clk_in);
    reset = 1'b1;
    raw   = raw_after;
    @(negedge clk_in);
    reset = 1'b0;
    n     = 0;
  endtask

  task automatic expect_reset_state(input string tag);
    expect_eq({tag, "_req"},   32'(pll_reset_req), 32'h3);
    expect_eq({tag, "_ready"}, 32'(ch_ready),      32'h0);
    expect_eq({tag, "_fail"},  32'(ch_fail),       32'h0);
    expect_eq({tag, "_all"},   32'(all_ready),     32'h0);
    expect_eq({tag, "_lost"},  32'(lock_lost),     32'h0);
  endtask

  initial begin
    reset = 1'b1;
    raw   = 2'b00;

    // Nominal lock: ready at 8 + 2 + 16 + 1 = 27
    apply_reset(2'b11);
    expect_reset_state("rst");
`ifdef PLL_LOCK_LOSS_COUNT_EN
    expect_eq("rst_loss_count", 32'(loss_count), 32'h0);
`endif
    advance_to(7);  expect_eq("nom_req_c7",   32'(pll_reset_req), 32'h3);
    advance_to(8);  expect_eq("nom_req_c8",   32'(pll_reset_req), 32'h0);
    advance_to(26); expect_eq("nom_ready_c26", 32'(ch_ready), 32'h0);
    advance_to(27); expect_eq("nom_ready_c27", 32'(ch_ready), 32'h3);
                    expect_eq("nom_all_c27",   32'(all_ready), 32'h1);

    // Lock loss: one-cycle raw drop on ch0 while both locked
    raw = 2'b10;
    advance_to(28); raw = 2'b11;
    advance_to(29); expect_eq("loss_lost_c29",  32'(lock_lost), 32'h0);
                    expect_eq("loss_ready_c29", 32'(ch_ready),  32'h3);
    advance_to(30); expect_eq("loss_lost_c30",  32'(lock_lost), 32'h1);
                    expect_eq("loss_ready_c30", 32'(ch_ready),  32'h2);
                    expect_eq("loss_all_c30",   32'(all_ready), 32'h0);
                    expect_eq("loss_req_c30",   32'(pll_reset_req), 32'h1);
    advance_to(31); expect_eq("loss_lost_c31",  32'(lock_lost), 32'h0);
    advance_to(37); expect_eq("loss_req_c37",   32'(pll_reset_req), 32'h1);
    advance_to(38); expect_eq("loss_req_c38",   32'(pll_reset_req), 32'h0);
    advance_to(56); expect_eq("loss_ready_c56", 32'(ch_ready),  32'h2);
    advance_to(57); expect_eq("loss_ready_c57", 32'(ch_ready),  32'h3);
                    expect_eq("loss_all_c57",   32'(all_ready), 32'h1);

    // Settle interruption: ch0 lk low while SETTLE count is 10
    apply_reset(2'b11);
    advance_to(19); raw = 2'b10;
    advance_to(20); raw = 2'b11;
    advance_to(22); expect_eq("settle_req_c22",   32'(pll_reset_req), 32'h0);
                    expect_eq("settle_ready_c22", 32'(ch_ready), 32'h0);
    advance_to(27); expect_eq("settle_ready_c27", 32'(ch_ready), 32'h2);
                    expect_eq("settle_all_c27",   32'(all_ready), 32'h0);
    advance_to(38); expect_eq("settle_ready_c38", 32'(ch_ready), 32'h2);
    advance_to(39); expect_eq("settle_ready_c39", 32'(ch_ready), 32'h3);
                    expect_eq("settle_all_c39",   32'(all_ready), 32'h1);

    // Lock edge on the timeout cycle: SETTLE wins, no reset issued
    apply_reset(2'b01);
    advance_to(69); raw = 2'b11;
    advance_to(72); expect_eq("edge_req_c72",   32'(pll_reset_req), 32'h0);
    advance_to(87); expect_eq("edge_ready_c87", 32'(ch_ready), 32'h1);
    advance_to(88); expect_eq("edge_ready_c88", 32'(ch_ready), 32'h3);
                    expect_eq("edge_all_c88",   32'(all_ready), 32'h1);

    // Retry then fail on ch1
    apply_reset(2'b01);
    advance_to(27);  expect_eq("retry_ready_c27", 32'(ch_ready), 32'h1);
                     expect_eq("retry_all_c27",   32'(all_ready), 32'h0);
    advance_to(71);  expect_eq("retry_req_c71",   32'(pll_reset_req), 32'h0);
    advance_to(72);  expect_eq("retry_req_c72",   32'(pll_reset_req), 32'h2);
    advance_to(79);  expect_eq("retry_req_c79",   32'(pll_reset_req), 32'h2);
    advance_to(80);  expect_eq("retry_req_c80",   32'(pll_reset_req), 32'h0);
    advance_to(143); expect_eq("retry_req_c143",  32'(pll_reset_req), 32'h0);
                     expect_eq("retry_fail_c143", 32'(ch_fail), 32'h0);
    advance_to(144); expect_eq("retry_req_c144",  32'(pll_reset_req), 32'h2);
    advance_to(151); expect_eq("retry_req_c151",  32'(pll_reset_req), 32'h2);
    advance_to(152); expect_eq("retry_req_c152",  32'(pll_reset_req), 32'h0);
    advance_to(215); expect_eq("retry_fail_c215", 32'(ch_fail), 32'h0);
    advance_to(216); expect_eq("retry_fail_c216", 32'(ch_fail), 32'h2);
                     expect_eq("retry_req_c216",  32'(pll_reset_req), 32'h2);
                     expect_eq("retry_ready_c216", 32'(ch_ready), 32'h1);
                     expect_eq("retry_all_c216",  32'(all_ready), 32'h0);
    advance_to(266); expect_eq("retry_fail_c266", 32'(ch_fail), 32'h2);
                     expect_eq("retry_req_c266",  32'(pll_reset_req), 32'h2);

    // Mid-operation reset with ch1 failed and ch0 locked
    apply_reset(2'b11);
    expect_reset_state("midrst");
    advance_to(27); expect_eq("midrst_ready_c27", 32'(ch_ready), 32'h3);
                    expect_eq("midrst_all_c27",   32'(all_ready), 32'h1);
                    expect_eq("midrst_fail_c27",  32'(ch_fail), 32'h0);

`ifdef PLL_LOCK_LOSS_COUNT_EN
    // 300 losses on ch0: each glitch relocks exactly 30 cycles later
    for (int i = 0; i < 300; i++) begin
      raw = 2'b10;
      advance_to(n + 1);
      raw = 2'b11;
      advance_to(n + 29);
      if (i == 0) expect_eq("cnt_first", 32'(loss_count), 32'h1);
    end
    expect_eq("cnt_ready_end", 32'(ch_ready), 32'h3);
    expect_eq("cnt_ch0_sat",   32'(loss_count[7:0]),  32'hFF);
    expect_eq("cnt_ch1_zero",  32'(loss_count[15:8]), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
